// File: rtl/wm8731_cfg_seq.sv
// wm8731_cfg_seq: walks the WM8731 register init table over an I2C master,
// retrying NACKed or timed-out words, then serves single run-time register
// writes on the same master.
//
// Handshakes:
//   - Master side: i2c_start is a one-cycle pulse. i2c_word holds from that
//     pulse until the master's one-cycle i2c_end pulse. i2c_nack qualifies
//     i2c_end.
//   - User side: wr_req is held with wr_addr/wr_data until the one-cycle
//     wr_ack pulse. wr_err qualifies wr_ack. Requests are accepted only in
//     IDLE, which is reached only after init_done.
module wm8731_cfg_seq #(
  parameter int         GAP_CYCLES     = 1000,
  parameter int         MAX_RETRY      = 3,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] DEV_ADDR       = 8'h34
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic        wr_req,
  input  logic [6:0]  wr_addr,
  input  logic [8:0]  wr_data,
  output logic        wr_ack,
  output logic        wr_err,
  output logic        i2c_start,
  output logic [23:0] i2c_word,
  input  logic        i2c_end,
  input  logic        i2c_nack,
  output logic        init_done,
  output logic        init_error,
  output logic        busy,
  output logic [3:0]  cfg_index,
  output logic [2:0]  dbg_state
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [GW-1:0] GAP_SHORT = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_FULL  = GW'(GAP_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);
  localparam logic [3:0]    LAST_IDX  = 4'd10;

  typedef enum logic [2:0] {
    S_GAP      = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_END = 3'd2,
    S_IDLE     = 3'd3,
    S_ERROR    = 3'd4
  } state_t;

  typedef enum logic {
    M_INIT = 1'b0,
    M_USER = 1'b1
  } mode_t;

  state_t          state, state_d;
  mode_t           mode, mode_d;
  logic [3:0]      idx_d;
  logic [3:0]      retry_cnt, retry_d;
  logic [GW-1:0]   gap_cnt, gap_d;
  logic [TW-1:0]   to_cnt, to_d;
  logic [23:0]     word_d;
  logic            start_d, ack_d, err_d, done_d, ierr_d, busy_d;
  logic            pend, pend_d;
  // Set when the current transfer is finished for good, so the gap that
  // follows ends in IDLE rather than ISSUE.
  logic            to_idle, to_idle_d;
  logic            xfer_ok, xfer_bad;

  // Register/data halves of the init words; DEV_ADDR is prepended on issue.
  function automatic logic [15:0] table_low(input logic [3:0] idx);
    case (idx)
      4'd0:    table_low = 16'h1E00;  // R15 reset
      4'd1:    table_low = 16'h0C00;  // R6 power
      4'd2:    table_low = 16'h0017;  // R0
      4'd3:    table_low = 16'h0217;  // R1
      4'd4:    table_low = 16'h0479;  // R2
      4'd5:    table_low = 16'h0679;  // R3
      4'd6:    table_low = 16'h0812;  // R4
      4'd7:    table_low = 16'h0A00;  // R5
      4'd8:    table_low = 16'h0E02;  // R7
      4'd9:    table_low = 16'h1000;  // R8
      4'd10:   table_low = 16'h1201;  // R9 active
      default: table_low = 16'h0000;
    endcase
  endfunction

  assign dbg_state = state;

  // Next-state and next-output logic for the whole sequencer.
  always_comb begin
    state_d   = state;
    mode_d    = mode;
    idx_d     = cfg_index;
    retry_d   = retry_cnt;
    gap_d     = gap_cnt;
    to_d      = to_cnt;
    word_d    = i2c_word;
    start_d   = 1'b0;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    done_d    = init_done;
    ierr_d    = init_error;
    pend_d    = pend;
    to_idle_d = to_idle;
    xfer_ok   = 1'b0;
    xfer_bad  = 1'b0;

    // A restart that cannot act now is remembered until it can.
    if (restart && (state != S_IDLE) && (state != S_ERROR)) pend_d = 1'b1;

    case (state)
      S_GAP: begin
        // The final gap runs one cycle longer so IDLE lands where the next
        // i2c_start would have.
        if (gap_cnt == (to_idle ? GAP_FULL : GAP_SHORT)) begin
          gap_d = '0;
          if (to_idle) begin
            to_idle_d = 1'b0;
            state_d   = S_IDLE;
            if (mode == M_INIT) done_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          gap_d = gap_cnt + 1'b1;
        end
      end

      S_ISSUE: begin
        // Retries resend the captured word untouched.
        if (retry_cnt == 4'd0) begin
          word_d = (mode == M_USER) ? {DEV_ADDR, wr_addr, wr_data}
                                    : {DEV_ADDR, table_low(cfg_index)};
        end
        start_d = 1'b1;
        to_d    = '0;
        state_d = S_WAIT_END;
      end

      S_WAIT_END: begin
        // i2c_end beats a timeout expiring in the same cycle.
        if (i2c_end && !i2c_nack)           xfer_ok  = 1'b1;
        else if (i2c_end || to_cnt == TO_LAST) xfer_bad = 1'b1;
        else                                 to_d     = to_cnt + 1'b1;

        if (xfer_ok) begin
          retry_d = 4'd0;
          state_d = S_GAP;
          if (mode == M_USER) begin
            ack_d     = 1'b1;
            to_idle_d = 1'b1;
          end else if (pend) begin
            pend_d = 1'b0;
            idx_d  = 4'd0;
          end else if (cfg_index == LAST_IDX) begin
            to_idle_d = 1'b1;
          end else begin
            idx_d = cfg_index + 4'd1;
          end
        end else if (xfer_bad) begin
          if (retry_cnt < RETRY_MAX) begin
            retry_d = retry_cnt + 4'd1;
            state_d = S_GAP;
          end else begin
            retry_d = 4'd0;
            if (mode == M_USER) begin
              ack_d     = 1'b1;
              err_d     = 1'b1;
              to_idle_d = 1'b1;
              state_d   = S_GAP;
            end else begin
              ierr_d  = 1'b1;
              state_d = S_ERROR;
            end
          end
        end
      end

      S_IDLE, S_ERROR: begin
        if (restart || pend) begin
          pend_d  = 1'b0;
          done_d  = 1'b0;
          ierr_d  = 1'b0;
          idx_d   = 4'd0;
          retry_d = 4'd0;
          mode_d  = M_INIT;
          state_d = S_GAP;
        end else if (state == S_IDLE && wr_req && init_done) begin
          mode_d  = M_USER;
          retry_d = 4'd0;
          state_d = S_ISSUE;
        end
      end

      default: state_d = S_GAP;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_ERROR);
  end

  // State and registered outputs; reset returns everything to zero at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_GAP;
      mode       <= M_INIT;
      cfg_index  <= 4'd0;
      retry_cnt  <= 4'd0;
      gap_cnt    <= '0;
      to_cnt     <= '0;
      i2c_word   <= 24'd0;
      i2c_start  <= 1'b0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      init_done  <= 1'b0;
      init_error <= 1'b0;
      busy       <= 1'b0;
      pend       <= 1'b0;
      to_idle    <= 1'b0;
    end else begin
      state      <= state_d;
      mode       <= mode_d;
      cfg_index  <= idx_d;
      retry_cnt  <= retry_d;
      gap_cnt    <= gap_d;
      to_cnt     <= to_d;
      i2c_word   <= word_d;
      i2c_start  <= start_d;
      wr_ack     <= ack_d;
      wr_err     <= err_d;
      init_done  <= done_d;
      init_error <= ierr_d;
      busy       <= busy_d;
      pend       <= pend_d;
      to_idle    <= to_idle_d;
    end
  end

endmodule
